// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: AXI-Stream phase source for the CORDIC sin/cos core.
// Accumulates a clamped signed Q3.13 increment and wraps into [PI_NEG, PI_POS].
// Supports continuous or fixed-length bursts under full tready backpressure.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   phase_inc            : signed increment per beat, latched on start
//   num_samples          : beats per burst (0 = continuous), latched on start
//   start / stop         : single-cycle control pulses
//   m_axis_phase_tready  : sink ready
//   m_axis_phase_tvalid  : phase beat valid
//   m_axis_phase_tdata   : phase beat, signed Q3.13
//   busy                 : high whenever not idle
//   done                 : one-cycle pulse after the final beat
module cordic_phase_gen #(
  parameter int unsigned        PHASE_W = 16,
  parameter logic [PHASE_W-1:0] PI_POS  = 16'h6488,
  parameter logic [PHASE_W-1:0] PI_NEG  = 16'h9B78,
  parameter int unsigned        CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               start,
  input  logic               stop,
  input  logic               m_axis_phase_tready,
  output logic               m_axis_phase_tvalid,
  output logic [PHASE_W-1:0] m_axis_phase_tdata,
  output logic               busy,
  output logic               done
);

  localparam int unsigned SUM_W = PHASE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               tvalid_q, tvalid_d;
  logic [PHASE_W-1:0] tdata_q, tdata_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // Phase constants sign-extended to the sum width
  logic signed [SUM_W-1:0] pi_pos_x;
  logic signed [SUM_W-1:0] pi_neg_x;
  logic signed [SUM_W-1:0] two_pi_x;
  assign pi_pos_x = SUM_W'($signed(PI_POS));
  assign pi_neg_x = SUM_W'($signed(PI_NEG));
  assign two_pi_x = pi_pos_x - pi_neg_x;

  // Saturate the requested increment to [-PI_POS, PI_POS]
  logic signed [SUM_W-1:0] inc_in_x;
  logic [PHASE_W-1:0]      inc_clamped_c;
  assign inc_in_x = SUM_W'($signed(phase_inc));

  always_comb begin
    inc_clamped_c = phase_inc;
    if (inc_in_x > pi_pos_x) begin
      inc_clamped_c = PI_POS;
    end else if (inc_in_x < -pi_pos_x) begin
      inc_clamped_c = PHASE_W'(-pi_pos_x);
    end
  end

  // Next phase: widened add, then fold back once into [PI_NEG, PI_POS]
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] wrap_c;
  assign sum_c = SUM_W'($signed(tdata_q)) + SUM_W'($signed(inc_q));

  always_comb begin
    wrap_c = sum_c;
    if (sum_c > pi_pos_x) begin
      wrap_c = sum_c - two_pi_x;
    end else if (sum_c < pi_neg_x) begin
      wrap_c = sum_c + two_pi_x;
    end
  end

  // Handshake, saturating beat count and burst termination
  logic             hs_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             burst_end_c;
  assign hs_c        = tvalid_q && m_axis_phase_tready;
  assign cnt_inc_c   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign burst_end_c = hs_c && (num_q != '0) && (cnt_inc_c == num_q);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      inc_q    <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      inc_q    <= inc_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; a stop without a handshake parks the pending beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (hs_c && (stop || burst_end_c)) begin
          state_d = S_IDLE;
        end else if (stop) begin
          state_d = S_STOPPING;
        end
      end
      S_STOPPING: begin
        if (hs_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    inc_d    = inc_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          inc_d    = inc_clamped_c;
          num_d    = num_samples;
          tdata_d  = '0;
          cnt_d    = '0;
          tvalid_d = 1'b1;
        end
      end
      S_RUN, S_STOPPING: begin
        if (hs_c) begin
          cnt_d   = cnt_inc_c;
          tdata_d = PHASE_W'(wrap_c);
          if (state_d == S_IDLE) begin
            tvalid_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign m_axis_phase_tvalid = tvalid_q;
  assign m_axis_phase_tdata  = tdata_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed self-checking bench for cordic_phase_gen.
module tb_cordic_phase_gen;

  logic        clk;
  logic        rst;
  logic [15:0] phase_inc;
  logic [15:0] num_samples;
  logic        start;
  logic        stop;
  logic        tready;
  logic        tvalid;
  logic [15:0] tdata;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  cordic_phase_gen dut (
    .clk                 (clk),
    .rst                 (rst),
    .phase_inc           (phase_inc),
    .num_samples         (num_samples),
    .start               (start),
    .stop                (stop),
    .m_axis_phase_tready (tready),
    .m_axis_phase_tvalid (tvalid),
    .m_axis_phase_tdata  (tdata),
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ph();
    return int'($signed(tdata));
  endfunction

  // Advance one clock; inputs and outputs settle 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [15:0] inc, input logic [15:0] num);
    phase_inc   = inc;
    num_samples = num;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  // Stop with tready high: ends on this edge, done visible right after
  task automatic end_run(input string tag);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check({tag, "_end_tvalid"}, int'(tvalid), 0);
    check({tag, "_end_done"},   int'(done),   1);
    step();
    check({tag, "_done_clr"},   int'(done),   0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    phase_inc   = '0;
    num_samples = '0;
    start       = 1'b0;
    stop        = 1'b0;
    tready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", int'(tvalid), 0);
    check("rst_tdata",  ph(),         0);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    rst = 1'b0;
    step();

    // Continuous ramp of 200 with wrap at beat 129
    tready = 1'b1;
    start_burst(16'd200, 16'd0);
    check("r200_tvalid", int'(tvalid), 1);
    check("r200_busy",   int'(busy),   1);
    for (int k = 0; k <= 130; k++) begin
      case (k)
        0:   check("r200_b0",   ph(), 0);
        1:   check("r200_b1",   ph(), 200);
        2:   check("r200_b2",   ph(), 400);
        128: check("r200_b128", ph(), 25600);
        129: check("r200_b129", ph(), -25672);
        130: check("r200_b130", ph(), -25472);
        default: ;
      endcase
      step();
    end
    end_run("r200");
    check("r200_idle_busy", int'(busy), 0);

    // Positive wrap
    start_burst(16'd3000, 16'd0);
    repeat (8) step();
    check("p3000_b8", ph(), 24000);
    step();
    check("p3000_b9", ph(), -24472);
    end_run("p3000");

    // Negative wrap
    start_burst(16'hF448, 16'd0);
    repeat (8) step();
    check("n3000_b8", ph(), -24000);
    step();
    check("n3000_b9", ph(), 24472);
    end_run("n3000");

    // Positive clamp; +pi kept, 2*pi folds to 0
    start_burst(16'h7FFF, 16'd0);
    check("cp_b0", ph(), 0);
    step();
    check("cp_b1", ph(), 25736);
    step();
    check("cp_b2", ph(), 0);
    step();
    check("cp_b3", ph(), 25736);
    end_run("cp");

    // Negative clamp; -pi kept
    start_burst(16'h8000, 16'd0);
    step();
    check("cn_b1", ph(), -25736);
    step();
    check("cn_b2", ph(), 0);
    end_run("cn");

    // Burst of 4 with a 5-cycle stall on beat 3
    start_burst(16'd200, 16'd4);
    for (int k = 0; k < 3; k++) begin
      check("bst_pre", ph(), 200 * k);
      step();
    end
    tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bst_hold_tdata",  ph(),         600);
      check("bst_hold_tvalid", int'(tvalid), 1);
      step();
    end
    check("bst_hold_done", int'(done), 0);
    tready = 1'b1;
    step();
    check("bst_end_tvalid", int'(tvalid), 0);
    check("bst_end_done",   int'(done),   1);
    check("bst_end_busy",   int'(busy),   0);
    check("bst_next_phase", ph(),         800);
    step();
    check("bst_done_clr",   int'(done),   0);
    check("bst_stay_idle",  int'(tvalid), 0);

    // Stop under backpressure parks the beat in STOPPING
    start_burst(16'd100, 16'd0);
    step();
    step();
    check("stp_pre", ph(), 200);
    tready = 1'b0;
    stop   = 1'b1;
    step();
    stop   = 1'b0;
    start  = 1'b1;
    check("stp_hold_tvalid", int'(tvalid), 1);
    check("stp_hold_tdata",  ph(),         200);
    check("stp_hold_busy",   int'(busy),   1);
    step();
    start  = 1'b0;
    check("stp_hold2_tdata", ph(),         200);
    check("stp_hold2_done",  int'(done),   0);
    tready = 1'b1;
    step();
    check("stp_end_tvalid", int'(tvalid), 0);
    check("stp_end_done",   int'(done),   1);
    check("stp_end_busy",   int'(busy),   0);
    step();
    check("stp_done_clr",   int'(done),   0);

    // Asynchronous reset mid-burst, then restart from phase 0
    start_burst(16'd200, 16'd10);
    repeat (3) step();
    check("rr_pre", ph(), 600);
    rst = 1'b1;
    #1;
    check("rr_tvalid", int'(tvalid), 0);
    check("rr_tdata",  ph(),         0);
    check("rr_busy",   int'(busy),   0);
    check("rr_done",   int'(done),   0);
    #2;
    rst = 1'b0;
    step();
    check("rr_no_done", int'(done), 0);
    start_burst(16'd200, 16'd0);
    check("rr_restart_b0",     ph(),         0);
    check("rr_restart_tvalid", int'(tvalid), 1);
    step();
    check("rr_restart_b1",     ph(),         200);
    end_run("rr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
